alu_sequencer: RTL and testbench

Instruction sequencer for the 8-bit basic processor. Fetches two-byte instructions from a synchronous program memory and holds the accumulator. Executes NOP/LDI/HALT internally; dispatches every other opcode to the shared immediate-operand ALU units (AND, etc.) over the 4-bit op-code bus, waits for the unit's done flag, then writes the result back to the accumulator.

---
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit basic processor: fetches two-byte instructions,
// runs NOP/LDI/HALT itself and dispatches all other opcodes to the ALU units.
// Optional WAIT done-timeout is enabled with `define SEQ_TIMEOUT_EN.
module alu_sequencer #(
    parameter int DONE_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] pc,
    input  logic [7:0] mem_data,
    output logic [3:0] ctr1,
    output logic [7:0] data1,
    output logic [7:0] data2,
    input  logic [7:0] alu_result,
    input  logic       alu_done,
    output logic [7:0] acc,
    output logic       busy,
    output logic       halted,
    output logic       error
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE, FOP, DOP, FIMM, DIMM, DISPATCH, WAIT, HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] imm_q, imm_d;
    logic [3:0] ir_q, ir_d;
    logic       done_q;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(DONE_TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            acc_q   <= 8'h00;
            imm_q   <= 8'h00;
            ir_q    <= 4'h0;
            done_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            imm_q   <= imm_d;
            ir_q    <= ir_d;
            done_q  <= alu_done;
`ifdef SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            error_q <= error_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        imm_d   = imm_q;
        ir_d    = ir_q;
`ifdef SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        error_d = error_q;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = 8'h00;
                    state_d = FOP;
`ifdef SEQ_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            FOP: state_d = DOP;
            DOP: begin
                ir_d = mem_data[7:4];
                pc_d = pc_q + 8'd1;
                case (mem_data[7:4])
                    OP_NOP:  state_d = FOP;
                    OP_HALT: state_d = HALT;
                    default: state_d = FIMM;
                endcase
            end
            FIMM: state_d = DIMM;
            DIMM: begin
                imm_d = mem_data;
                pc_d  = pc_q + 8'd1;
                if (ir_q == OP_LDI) begin
                    acc_d   = mem_data;
                    state_d = FOP;
                end else begin
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                state_d = WAIT;
`ifdef SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // Only a fresh rising edge counts; a level already high on entry is stale.
                if (alu_done && !done_q) begin
                    acc_d   = alu_result;
                    state_d = FOP;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc     = pc_q;
    assign ctr1   = (state_q == DISPATCH) ? ir_q : 4'b0000;
    assign data1  = acc_q;
    assign data2  = imm_q;
    assign acc    = acc_q;
    assign busy   = (state_q != IDLE) && (state_q != HALT);
    assign halted = (state_q == HALT);
`ifdef SEQ_TIMEOUT_EN
    assign error  = error_q;
`else
    assign error  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a synchronous program memory, an AND unit
// model and an accumulator scoreboard fed by the stimulus and drained by a monitor.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] pc;
   logic [7:0] memData = 8'h00;
   logic [3:0] ctr1;
   logic [7:0] data1;
   logic [7:0] data2;
   logic [7:0] aluResult;
   logic       aluDone;
   logic [7:0] acc;
   logic       busy;
   logic       halted;
   logic       error;

   logic [7:0] mem [256];
   logic       forceDone = 1'b0;
   logic       unitEnable = 1'b1;
   logic [7:0] unitResult = 8'h00;
   logic [2:0] unitCnt = 3'd0;
   logic [7:0] expQ [$];
   logic [7:0] prevAcc = 8'h00;
   logic [7:0] pcExp [11] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5};
   int         checks = 0;
   int         errors = 0;

   alu_sequencer #(.DONE_TIMEOUT(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pc         (pc),
      .mem_data   (memData),
      .ctr1       (ctr1),
      .data1      (data1),
      .data2      (data2),
      .alu_result (aluResult),
      .alu_done   (aluDone),
      .acc        (acc),
      .busy       (busy),
      .halted     (halted),
      .error      (error)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Synchronous program memory: data for the address presented appears next cycle
   always @(posedge clk) memData <= mem[pc];

   // AND unit: samples ctr1 at the end of DISPATCH, holds done for four cycles and keeps its result
   always @(posedge clk) begin
      if (unitCnt != 3'd0) unitCnt <= unitCnt - 3'd1;
      if (unitEnable && ctr1 == 4'hE) begin
         unitResult <= data1 & data2;
         unitCnt    <= 3'd4;
      end
   end

   assign aluDone   = (unitCnt != 3'd0) || forceDone;
   assign aluResult = unitResult;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic startVal, input logic forceVal);
      start     = startVal;
      forceDone = forceVal;
   endtask

   task automatic startPulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic waitHalted(input string tag);
      int n = 0;
      while (!halted && n < 60) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(halted), 32'd1);
   endtask

   // Scoreboard monitor: every accumulator change outside reset must match the next expected value
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevAcc = acc;
         end else if (acc !== prevAcc) begin
            if (expQ.size() == 0) begin
               checkOutput("sbUnexpected", 32'(acc), 32'(prevAcc));
            end else begin
               checkOutput("sbAcc", 32'(acc), 32'(expQ.pop_front()));
            end
            prevAcc = acc;
         end
      end
   end

   // Watchdog so that a stuck design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      clearMem();
      tick();
      tick();
      checkOutput("rstPc", 32'(pc), 32'd0);
      checkOutput("rstAcc", 32'(acc), 32'd0);
      checkOutput("rstCtr1", 32'(ctr1), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstHalted", 32'(halted), 32'd0);
      checkOutput("rstError", 32'(error), 32'd0);
      rst_n = 1'b1;
      tick();

      // LDI F3, ANDI 5C, HALT with cycle-exact dispatch and writeback
      $display("[TB] program LDI/ANDI/HALT");
      mem[0] = 8'h10; mem[1] = 8'hF3; mem[2] = 8'hE0; mem[3] = 8'h5C; mem[4] = 8'hF0;
      expQ.push_back(8'hF3);
      expQ.push_back(8'h50);
      startPulse();
      for (int c = 0; c <= 12; c++) begin
         checkOutput("andCtr1", 32'(ctr1), (c == 8) ? 32'hE : 32'h0);
         if (c == 0) checkOutput("andBusy", 32'(busy), 32'd1);
         if (c == 8) checkOutput("andData1", 32'(data1), 32'hF3);
         if (c == 8) checkOutput("andData2", 32'(data2), 32'h5C);
         if (c == 9) checkOutput("andAccBefore", 32'(acc), 32'hF3);
         if (c == 10) checkOutput("andAccAfter", 32'(acc), 32'h50);
         if (c < 12) tick();
      end
      checkOutput("andHalted", 32'(halted), 32'd1);
      checkOutput("andPc", 32'(pc), 32'd5);
      checkOutput("andBusyEnd", 32'(busy), 32'd0);

      // start pulsed while busy must not disturb the pc sequence
      $display("[TB] start while busy");
      clearMem();
      mem[2] = 8'h10; mem[3] = 8'h33; mem[4] = 8'hF0;
      expQ.push_back(8'h33);
      startPulse();
      for (int c = 0; c <= 10; c++) begin
         checkOutput("busyPc", 32'(pc), 32'(pcExp[c]));
         applyStimulus((c == 3) || (c == 7), 1'b0);
         if (c < 10) tick();
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("busyHalted", 32'(halted), 32'd1);

      // Stale done level held across DISPATCH is ignored until a fresh rising edge
      $display("[TB] stale done");
      clearMem();
      mem[0] = 8'h10; mem[1] = 8'hAA; mem[2] = 8'hE0; mem[3] = 8'h0F; mem[4] = 8'hF0;
      expQ.push_back(8'hAA);
      expQ.push_back(8'h0A);
      applyStimulus(1'b0, 1'b1);
      startPulse();
      for (int c = 0; c < 9; c++) tick();
      for (int c = 9; c <= 15; c++) begin
         checkOutput("staleAccHeld", 32'(acc), 32'hAA);
         if (c < 15) tick();
      end
      checkOutput("staleBusy", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b0);
      tick();
      checkOutput("staleAccLow", 32'(acc), 32'hAA);
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("staleAccWb", 32'(acc), 32'h0A);
      applyStimulus(1'b0, 1'b0);
      waitHalted("staleHalted");

      // No done response at all
      $display("[TB] missing done");
      clearMem();
      mem[0] = 8'h10; mem[1] = 8'h77; mem[2] = 8'hE0; mem[3] = 8'h11; mem[4] = 8'hF0;
      expQ.push_back(8'h77);
      unitEnable = 1'b0;
      startPulse();
      for (int c = 0; c < 16; c++) tick();
      checkOutput("toBusyLastWait", 32'(busy), 32'd1);
      checkOutput("toErrorLastWait", 32'(error), 32'd0);
      tick();
`ifdef SEQ_TIMEOUT_EN
      checkOutput("toHalted", 32'(halted), 32'd1);
      checkOutput("toError", 32'(error), 32'd1);
      checkOutput("toAcc", 32'(acc), 32'h77);
      clearMem();
      mem[0] = 8'hF0;
      startPulse();
      checkOutput("toErrorCleared", 32'(error), 32'd0);
      checkOutput("toPcCleared", 32'(pc), 32'd0);
      waitHalted("toRestartHalted");
`else
      for (int c = 0; c < 14; c++) tick();
      checkOutput("holdBusy", 32'(busy), 32'd1);
      checkOutput("holdError", 32'(error), 32'd0);
      checkOutput("holdAcc", 32'(acc), 32'h77);
      expQ.push_back(8'h0A);
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("holdAccWb", 32'(acc), 32'h0A);
      waitHalted("holdHalted");
      checkOutput("holdErrorEnd", 32'(error), 32'd0);
`endif

      // Reset asserted mid-WAIT, then a late done must not write the accumulator
      $display("[TB] reset mid-WAIT");
      clearMem();
      mem[0] = 8'hE0; mem[1] = 8'h3C; mem[2] = 8'hF0;
      startPulse();
      for (int c = 0; c < 5; c++) tick();
      checkOutput("midWaitBusy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      tick();
      checkOutput("midRstPc", 32'(pc), 32'd0);
      checkOutput("midRstAcc", 32'(acc), 32'd0);
      checkOutput("midRstCtr1", 32'(ctr1), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstHalted", 32'(halted), 32'd0);
      checkOutput("midRstError", 32'(error), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      tick();
      checkOutput("lateDoneAcc", 32'(acc), 32'd0);
      checkOutput("lateDoneBusy", 32'(busy), 32'd0);
      unitEnable = 1'b1;

      // Memory full of NOPs: pc wraps from FF to 00 and execution carries on
      $display("[TB] pc wrap");
      clearMem();
      startPulse();
      for (int c = 0; c <= 514; c++) begin
         if (c >= 508 && (c % 2) == 0) checkOutput("wrapPc", 32'(pc), 32'((c / 2) % 256));
         if (c < 514) tick();
      end
      checkOutput("wrapBusy", 32'(busy), 32'd1);
      checkOutput("wrapError", 32'(error), 32'd0);

      checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
